axi_dw_rd_sequencer: RTL
========================

# axi_dw_rd_sequencer

Read-channel controller for the AXI data-width downsizer path (slave port wider than master port). Converts each slave-port AR into one or more master-port ARs and sequences the returning narrow R beats into wide slave beats. It drives the lane-select and completion controls of the packing datapath, and limits outstanding slave reads to `AxiMaxReads`.

## Interface
**Parameters**
- `AxiMaxReads`, default 4: maximum outstanding slave-port reads; sets descriptor FIFO depth.
- `AxiSlvPortDataWidth`, default 64: slave data width in bits. SlvBytes = /8.
- `AxiMstPortDataWidth`, default 32: master data width in bits, strictly less than the slave width. MstBytes = /8. Ratio = SlvBytes/MstBytes, a power of 2.
- `AxiAddrWidth`, default 32: address width.

**Ports**
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `slv_ar_valid_i` / `slv_ar_ready_o`, in/out, 1: slave AR handshake.
- `slv_ar_addr_i`, in, AxiAddrWidth. `slv_ar_len_i`, in, 8. `slv_ar_size_i`, in, 3. `slv_ar_burst_i`, in, 2.
- `mst_ar_valid_o` / `mst_ar_ready_i`, out/in, 1: master AR handshake.
- `mst_ar_addr_o`, out, AxiAddrWidth. `mst_ar_len_o`, out, 8. `mst_ar_size_o`, out, 3. `mst_ar_burst_o`, out, 2.
- `mst_r_valid_i` / `mst_r_ready_o`, in/out, 1: master R handshake.
- `slv_r_valid_o` / `slv_r_ready_i`, out/in, 1: slave R handshake.
- `slv_r_last_o`, out, 1: last slave beat of the head transaction.
- `lane_sel_o`, out, log2(Ratio): MstBytes slice of the wide beat that the current master beat fills.
- `lane_we_o`, out, 1: write the current master data into the lane register (equals `mst_r_valid_i & mst_r_ready_o`).
- `unsupported_o`, out, 1: one-cycle pulse on acceptance of an unsupported burst.

## Operation
**Modes per slave AR** (s = `slv_ar_size_i`):
- **Narrow mode**, when 2^s ≤ MstBytes:
  - One master AR: addr, len, size and burst are forwarded unchanged.
  - Every master beat completes one slave beat.
- **Convert mode**, when 2^s > MstBytes:
  - Beats per slave beat: k = 2^s/MstBytes.
  - Start address A = addr aligned down to 2^s. Total master beats T = (len+1)·k.
  - Master ARs are issued in chunks of 256 beats. Chunk i has addr A + i·256·MstBytes, size log2(MstBytes), burst INCR, and len min(256, T − 256i) − 1.
  - Non-INCR bursts with len ≠ 0 are converted as INCR and pulse `unsupported_o` in the acceptance cycle.

**AR FSM**
- **IDLE**: `slv_ar_ready_o` = !fifo_full.
  - On handshake: latch the request, push a descriptor (mode, s, k, len, burst, addr) and go to ISSUE.
- **ISSUE**: `slv_ar_ready_o` = 0, `mst_ar_valid_o` = 1 with the current chunk; the fields stay stable until the handshake.
  - On handshake: if more chunks remain, advance to the next chunk and stay in ISSUE; otherwise return to IDLE.

**R sequencing** (always against the FIFO head)
- FIFO empty: `mst_r_ready_o` = 0 and `slv_r_valid_o` = 0.
- Completing beat: narrow mode, or the k-th master beat of a group in convert mode.
- `slv_r_valid_o` = `mst_r_valid_i` & completing.
- `mst_r_ready_o` = completing ? `slv_r_ready_i` : 1.
- `lane_sel_o`:
  - Convert mode: starts at (A/MstBytes) mod Ratio and increments mod Ratio on each `lane_we_o`.
  - Narrow mode: (cur_addr/MstBytes) mod Ratio.
    - cur_addr advances by 2^s per beat for INCR.
    - cur_addr stays fixed for FIXED.
    - For WRAP, cur_addr wraps within the (len+1)·2^s boundary.
- The slave-beat counter increments on each slave handshake.
- `slv_r_last_o` = (counter == head.len) & `slv_r_valid_o`.
- Slave handshake with `slv_r_last_o`: pop the FIFO and clear the counters.
- Master `rlast` is ignored.

**Boundaries**
- FIFO full: `slv_ar_ready_o` = 0 until a pop.
- Pop and push in the same cycle are allowed while full. The ready computation uses the registered full flag, so the next AR is accepted the cycle after the pop.
- Reset mid-operation: FIFO flushed, FSM to IDLE, all counters cleared.

## Timing
- Reset values:
  - `slv_ar_ready_o` = 1.
  - `mst_ar_valid_o`, `mst_r_ready_o`, `slv_r_valid_o`, `slv_r_last_o`, `lane_we_o`, `unsupported_o` = 0.
  - `lane_sel_o` = 0.
  - All master AR fields = 0.
- AR latency: slave handshake in cycle N gives `mst_ar_valid_o` in cycle N+1. Back-to-back chunks are issued every cycle while `mst_ar_ready_i` is high.
- The R path is combinational (zero latency) from `mst_r_valid_i` / `slv_r_ready_i` to the R outputs.
- `slv_ar_ready_o` and `mst_ar_valid_o` depend only on registers.

## Test plan
Configuration for all scenarios: Slv 64, Mst 32 (Ratio 2), `AxiMaxReads` 4.
- **Convert:** AR addr 0x100, len 3, size 3, INCR.
  - Master AR: addr 0x100, len 7, size 2.
  - 8 master beats with lanes 0,1,0,1,…; `slv_r_valid_o` on beats 2, 4, 6, 8; `slv_r_last_o` on beat 8.
- **Narrow:** AR addr 0x104, len 1, size 2, INCR.
  - Master AR identical to the slave AR.
  - Lanes 1, 0; every beat completes; last on beat 2.
- **Split:** AR addr 0x0, len 255, size 3.
  - Master ARs: (0x0, len 255) then (0x400, len 255) in consecutive cycles.
  - 512 master beats, 256 slave beats, a single `slv_r_last_o`.
- **Full:** 5 back-to-back ARs, no R.
  - 4 accepted; `slv_ar_ready_o` stays low.
  - The fifth AR is accepted the cycle after the first `slv_r_last_o` handshake.
- **Backpressure:** `slv_r_ready_i` low during a completing beat.
  - `mst_r_ready_o` low and the lane held.
  - The odd (non-completing) beat is still accepted with `lane_we_o` = 1.
- **Reset:** assert `rst_ni` mid-burst in the split case.
  - All outputs return to reset values.
  - A new AR is accepted normally afterwards.

Source files
------------

// File: rtl/axi_dw_rd_sequencer.sv
// -----------------------------------------------------------------------------
// axi_dw_rd_sequencer
//
// Read-channel controller for an AXI data-width downsizer (wide slave port,
// narrow master port). Each slave AR becomes one or more master ARs. The
// returning narrow R beats are sequenced into wide slave beats. The block
// drives the lane-select and lane-write controls of the external packing
// datapath and limits outstanding slave reads to AxiMaxReads.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   slv_ar_*                slave-port AR request (valid/ready, addr/len/size/burst)
//   mst_ar_*                master-port AR request, registered
//   mst_r_valid_i/ready_o   master R handshake (rlast is not needed here)
//   slv_r_valid_o/ready_i   slave R handshake
//   slv_r_last_o            last slave beat of the head transaction
//   lane_sel_o              MstBytes slice of the wide beat filled by this beat
//   lane_we_o               write current master data into the lane register
//   unsupported_o           pulse when a non-INCR multi-beat burst is converted
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A source holds valid and its
// payload stable until the transfer; valid never waits on ready.
// -----------------------------------------------------------------------------
module axi_dw_rd_sequencer #(
   parameter int unsigned AxiMaxReads         = 4,
   parameter int unsigned AxiSlvPortDataWidth = 64,
   parameter int unsigned AxiMstPortDataWidth = 32,
   parameter int unsigned AxiAddrWidth        = 32,
   localparam int unsigned SlvBytes = AxiSlvPortDataWidth / 8,
   localparam int unsigned MstBytes = AxiMstPortDataWidth / 8,
   localparam int unsigned Ratio    = SlvBytes / MstBytes,
   localparam int unsigned LaneW    = (Ratio > 1) ? $clog2(Ratio) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // slave AR
   input  logic                    slv_ar_valid_i,
   output logic                    slv_ar_ready_o,
   input  logic [AxiAddrWidth-1:0] slv_ar_addr_i,
   input  logic [7:0]              slv_ar_len_i,
   input  logic [2:0]              slv_ar_size_i,
   input  logic [1:0]              slv_ar_burst_i,
   // master AR
   output logic                    mst_ar_valid_o,
   input  logic                    mst_ar_ready_i,
   output logic [AxiAddrWidth-1:0] mst_ar_addr_o,
   output logic [7:0]              mst_ar_len_o,
   output logic [2:0]              mst_ar_size_o,
   output logic [1:0]              mst_ar_burst_o,
   // master R
   input  logic                    mst_r_valid_i,
   output logic                    mst_r_ready_o,
   // slave R
   output logic                    slv_r_valid_o,
   input  logic                    slv_r_ready_i,
   output logic                    slv_r_last_o,
   // packing datapath control
   output logic [LaneW-1:0]        lane_sel_o,
   output logic                    lane_we_o,
   output logic                    unsupported_o
);

   localparam int unsigned MstSizeI = $clog2(MstBytes);
   localparam logic [2:0]  MstSize  = 3'(MstSizeI);
   localparam int unsigned PtrW     = (AxiMaxReads > 1) ? $clog2(AxiMaxReads) : 1;
   localparam int unsigned CntW     = $clog2(AxiMaxReads + 1);

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   // Address step between 256-beat master chunks.
   localparam logic [AxiAddrWidth-1:0] ChunkBytes = AxiAddrWidth'(256 * MstBytes);
   localparam logic [AxiAddrWidth-1:0] AddrOne    = AxiAddrWidth'(1);

   // Per-transaction descriptor kept for the R sequencing.
   typedef struct packed {
      logic                    narrow;
      logic [2:0]              size;
      logic [7:0]              len;
      logic [1:0]              burst;
      logic [AxiAddrWidth-1:0] addr;   // aligned start address in convert mode
   } desc_t;

   typedef enum logic [0:0] {
      Idle  = 1'b0,
      Issue = 1'b1
   } state_e;

   // ---------------------------------------------------------------------------
   // Descriptor FIFO
   // ---------------------------------------------------------------------------
   desc_t            mem [AxiMaxReads];
   logic [PtrW-1:0]  wptr;
   logic [PtrW-1:0]  rptr;
   logic [CntW-1:0]  count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   desc_t            new_desc;
   desc_t            head;

   assign fifo_full  = (count == CntW'(AxiMaxReads));
   assign fifo_empty = (count == '0);
   assign head       = mem[rptr];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr] <= new_desc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= (wptr == PtrW'(AxiMaxReads - 1)) ? '0 : wptr + PtrW'(1);
         end
         if (pop) begin
            rptr <= (rptr == PtrW'(AxiMaxReads - 1)) ? '0 : rptr + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // AR path
   // ---------------------------------------------------------------------------
   state_e                  state;
   logic                    ar_valid;
   logic [AxiAddrWidth-1:0] ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic [13:0]             ar_rem;      // master beats left, current chunk included
   logic [13:0]             rem_next;

   logic                    req_narrow;
   logic [AxiAddrWidth-1:0] req_mask;
   logic [AxiAddrWidth-1:0] req_aligned;
   logic [2:0]              req_shift;
   logic [13:0]             req_total;
   logic                    accept;

   always_comb begin
      req_narrow  = (slv_ar_size_i <= MstSize);
      req_mask    = (AddrOne << slv_ar_size_i) - AddrOne;
      req_aligned = slv_ar_addr_i & ~req_mask;
      // Only meaningful in convert mode, where size exceeds MstSize.
      req_shift   = slv_ar_size_i - MstSize;
      req_total   = (14'(slv_ar_len_i) + 14'd1) << req_shift;
      rem_next    = ar_rem - 14'd256;
   end

   // Both depend on registers only.
   assign slv_ar_ready_o = (state == Idle) && !fifo_full;
   assign accept         = slv_ar_valid_i && slv_ar_ready_o;
   assign push           = accept;

   assign unsupported_o = accept && !req_narrow &&
                          (slv_ar_burst_i != BurstIncr) && (slv_ar_len_i != 8'd0);

   always_comb begin
      new_desc        = '0;
      new_desc.narrow = req_narrow;
      new_desc.size   = slv_ar_size_i;
      new_desc.len    = slv_ar_len_i;
      new_desc.burst  = slv_ar_burst_i;
      new_desc.addr   = req_narrow ? slv_ar_addr_i : req_aligned;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= Idle;
         ar_valid <= 1'b0;
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
         ar_rem   <= '0;
      end else begin
         case (state)
            Idle: begin
               if (accept) begin
                  state    <= Issue;
                  ar_valid <= 1'b1;
                  if (req_narrow) begin
                     ar_addr  <= slv_ar_addr_i;
                     ar_len   <= slv_ar_len_i;
                     ar_size  <= slv_ar_size_i;
                     ar_burst <= slv_ar_burst_i;
                     ar_rem   <= '0;
                  end else begin
                     ar_addr  <= req_aligned;
                     ar_len   <= (req_total > 14'd256) ? 8'd255 : 8'(req_total - 14'd1);
                     ar_size  <= MstSize;
                     ar_burst <= BurstIncr;
                     ar_rem   <= req_total;
                  end
               end
            end
            Issue: begin
               if (mst_ar_ready_i) begin
                  if (ar_rem > 14'd256) begin
                     // Another chunk follows directly; fields change only here.
                     ar_rem  <= rem_next;
                     ar_addr <= ar_addr + ChunkBytes;
                     ar_len  <= (rem_next > 14'd256) ? 8'd255 : 8'(rem_next - 14'd1);
                  end else begin
                     state    <= Idle;
                     ar_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= Idle;
               ar_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mst_ar_valid_o = ar_valid;
   assign mst_ar_addr_o  = ar_addr;
   assign mst_ar_len_o   = ar_len;
   assign mst_ar_size_o  = ar_size;
   assign mst_ar_burst_o = ar_burst;

   // ---------------------------------------------------------------------------
   // R path (combinational from the R handshake inputs)
   // ---------------------------------------------------------------------------
   logic [7:0]              slv_cnt;     // slave beats done for the head
   logic [7:0]              mcnt;        // master beats done for the head
   logic [AxiAddrWidth-1:0] cur_addr;
   logic                    started;     // cur_addr holds a computed address

   logic                    head_valid;
   logic [7:0]              kmask;
   logic                    completing;
   logic [AxiAddrWidth-1:0] eff_addr;
   logic [AxiAddrWidth-1:0] beat_bytes;
   logic [AxiAddrWidth-1:0] incr_addr;
   logic [AxiAddrWidth-1:0] wrap_bytes;
   logic [AxiAddrWidth-1:0] wrap_addr;
   logic [AxiAddrWidth-1:0] next_addr;
   logic [LaneW-1:0]        lane;
   logic                    slv_hs;

   always_comb begin
      head_valid = !fifo_empty;
      // k - 1 where k master beats make one slave beat (convert mode only).
      kmask      = (8'd1 << (head.size - MstSize)) - 8'd1;
      completing = head.narrow || ((mcnt & kmask) == kmask);

      // Narrow mode tracks the real beat address; before the first beat it
      // is the descriptor address itself.
      eff_addr   = started ? cur_addr : head.addr;
      beat_bytes = AddrOne << head.size;
      // Later INCR beats are size-aligned, so an unaligned start snaps down.
      incr_addr  = (eff_addr & ~(beat_bytes - AddrOne)) + beat_bytes;
      wrap_bytes = (AxiAddrWidth'(head.len) + AddrOne) << head.size;
      wrap_addr  = (eff_addr & ~(wrap_bytes - AddrOne)) |
                   (incr_addr & (wrap_bytes - AddrOne));
      case (head.burst)
         BurstFixed: next_addr = eff_addr;
         BurstWrap:  next_addr = wrap_addr;
         default:    next_addr = incr_addr;
      endcase

      if (head.narrow) begin
         lane = eff_addr[MstSizeI +: LaneW];
      end else begin
         // Adding in LaneW bits gives the mod-Ratio wrap for free.
         lane = head.addr[MstSizeI +: LaneW] + mcnt[LaneW-1:0];
      end
   end

   assign slv_r_valid_o = head_valid && mst_r_valid_i && completing;
   assign mst_r_ready_o = head_valid && (completing ? slv_r_ready_i : 1'b1);
   assign lane_we_o     = mst_r_valid_i && mst_r_ready_o;
   assign slv_r_last_o  = slv_r_valid_o && (slv_cnt == head.len);
   assign lane_sel_o    = head_valid ? lane : '0;
   assign slv_hs        = slv_r_valid_o && slv_r_ready_i;
   assign pop           = slv_hs && slv_r_last_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slv_cnt  <= '0;
         mcnt     <= '0;
         cur_addr <= '0;
         started  <= 1'b0;
      end else if (pop) begin
         slv_cnt  <= '0;
         mcnt     <= '0;
         started  <= 1'b0;
      end else begin
         if (lane_we_o) begin
            mcnt     <= mcnt + 8'd1;
            cur_addr <= next_addr;
            started  <= 1'b1;
         end
         if (slv_hs) begin
            slv_cnt <= slv_cnt + 8'd1;
         end
      end
   end

endmodule
